// File: rtl/pid_iterm_sched.sv
// -----------------------------------------------------------------------------
// pid_iterm_sched
//
// Time-shared integral-term engine for the two PID control loops. One
// saturate/add datapath is shared round-robin between channel 0 and channel 1.
// Each channel has its own 15-bit integrator that freezes on signed overflow.
// The 9-bit I-term of each channel is the top nine integrator bits.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   moving   in   high enables integration; low clears integrators and pending work
//   err_vld  in   [1:0] one-cycle strobe per channel, bit c qualifies err<c>
//   err0     in   [11:0] signed error, channel 0
//   err1     in   [11:0] signed error, channel 1
//   I_term0  out  [8:0] signed, integ0[14:6]
//   I_term1  out  [8:0] signed, integ1[14:6]
//   done     out  [1:0] one-cycle pulse on bit c after channel c's integrator write
//   ovr      out  [1:0] sticky overrun flag per channel (cleared by reset only)
// -----------------------------------------------------------------------------
module pid_iterm_sched (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               moving,
  input  logic [1:0]         err_vld,
  input  logic signed [11:0] err0,
  input  logic signed [11:0] err1,
  output logic signed [8:0]  I_term0,
  output logic signed [8:0]  I_term1,
  output logic [1:0]         done,
  output logic [1:0]         ovr
);

  localparam int DATA_W = 12;
  localparam int SAT_W  = 10;
  localparam int ACC_W  = 15;

  localparam logic signed [DATA_W-1:0] SAT_HI = 12'sd511;
  localparam logic signed [DATA_W-1:0] SAT_LO = -12'sd512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACC  = 2'd2
  } state_t;

  // Clamp a 12-bit error into the 10-bit range the integrator accepts.
  function automatic logic signed [SAT_W-1:0] sat10(input logic signed [DATA_W-1:0] x);
    if (x > SAT_HI)
      return 10'sh1FF;
    else if (x < SAT_LO)
      return 10'sh200;
    else
      return x[SAT_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] sext15(input logic signed [SAT_W-1:0] x);
    return {{(ACC_W-SAT_W){x[SAT_W-1]}}, x};
  endfunction

  // Signed overflow of a + b: operands agree in sign and the sum does not.
  function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                   input logic signed [ACC_W-1:0] b,
                                   input logic signed [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  state_t                    state, state_nxt;
  logic [1:0]                pend;
  logic                      last;
  logic                      cur_p1;
  logic signed [DATA_W-1:0]  err_lat0_p0, err_lat1_p0;
  logic signed [SAT_W-1:0]   sat_p1;
  logic signed [ACC_W-1:0]   integ0, integ1;

  logic                      grant_vld;
  logic                      grant;
  logic [1:0]                clr;
  logic signed [ACC_W-1:0]   acc_p2, add_p2, sum_p2;
  logic                      ovf_p2;

  // ---- stage 0: request latch and arbitration ----
  always_comb begin
    grant_vld = moving && (state == IDLE) && (pend != 2'b00);
    // Tie goes to the channel that was not served last.
    if (pend == 2'b11)
      grant = ~last;
    else
      grant = pend[1];
    clr = 2'b00;
    if (grant_vld)
      clr = grant ? 2'b10 : 2'b01;
  end

  // A strobe landing on the grant edge of its own channel re-arms pend and is
  // not an overrun: the clear is masked by the new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= 2'b00;
      ovr    <= 2'b00;
      last   <= 1'b1;
      cur_p1 <= 1'b0;
    end else if (!moving) begin
      pend <= 2'b00;
    end else begin
      pend <= (pend & ~clr) | err_vld;
      ovr  <= ovr | (err_vld & pend & ~clr);
      if (grant_vld) begin
        cur_p1 <= grant;
        last   <= grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (moving && err_vld[0])
      err_lat0_p0 <= err0;
    if (moving && err_vld[1])
      err_lat1_p0 <= err1;
  end

  // ---- stage 1: granted error saturated into sat_p1 ----
  always_ff @(posedge clk) begin
    if (grant_vld)
      sat_p1 <= sat10(grant ? err_lat1_p0 : err_lat0_p0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else if (!moving)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend != 2'b00) state_nxt = LOAD;
      LOAD:    state_nxt = ACC;
      ACC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage 2: accumulate into the selected integrator ----
  always_comb begin
    acc_p2 = cur_p1 ? integ1 : integ0;
    add_p2 = sext15(sat_p1);
    sum_p2 = acc_p2 + add_p2;
    ovf_p2 = add_ovf(acc_p2, add_p2, sum_p2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ0 <= '0;
      integ1 <= '0;
    end else if (!moving) begin
      integ0 <= '0;
      integ1 <= '0;
    end else if (state == LOAD && !ovf_p2) begin
      if (cur_p1)
        integ1 <= sum_p2;
      else
        integ0 <= sum_p2;
    end
  end

  // ---- outputs ----
  always_comb begin
    done = 2'b00;
    if (state == ACC)
      done = cur_p1 ? 2'b10 : 2'b01;
  end

  assign I_term0 = integ0[ACC_W-1:ACC_W-9];
  assign I_term1 = integ1[ACC_W-1:ACC_W-9];

endmodule

// File: tb/tb_pid_iterm_sched.sv
module tb_pid_iterm_sched;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               moving = 1'b0;
  logic [1:0]         err_vld = 2'b00;
  logic signed [11:0] err0 = '0;
  logic signed [11:0] err1 = '0;
  logic signed [8:0]  I_term0, I_term1;
  logic [1:0]         done, ovr;

  pid_iterm_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .moving  (moving),
    .err_vld (err_vld),
    .err0    (err0),
    .err1    (err1),
    .I_term0 (I_term0),
    .I_term1 (I_term1),
    .done    (done),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         ch;
    logic [8:0] it0;
    logic [8:0] it1;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check9(input string name, input logic [8:0] act, input logic [8:0] exp);
    check(name, {23'd0, act}, {23'd0, exp});
  endtask

  task automatic push(input int c, input int ch, input logic [8:0] it0, input logic [8:0] it1);
    exp_t e;
    e.cyc = c; e.ch = ch; e.it0 = it0; e.it1 = it1;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest expected update.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done !== 2'b00) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done=%b at cyc %0d, expected no pulse", done, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_ch", {30'd0, done}, (e.ch == 0) ? 32'd1 : 32'd2);
        check("done_cyc", cyc, e.cyc);
        check9("I_term0", I_term0, e.it0);
        check9("I_term1", I_term1, e.it1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [1:0] m, input logic signed [11:0] e0,
                        input logic signed [11:0] e1, output int k);
    @(negedge clk);
    k = cyc;
    err_vld = m;
    err0 = e0;
    err1 = e1;
    @(negedge clk);
    err_vld = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    moving = 1'b0;
    err_vld = 2'b00;
    #1;
    check9("rst_I_term0", I_term0, 9'd0);
    check9("rst_I_term1", I_term1, 9'd0);
    check("rst_done", {30'd0, done}, 32'd0);
    check("rst_ovr", {30'd0, ovr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    moving = 1'b1;
  endtask

  initial begin
    int k;
    int t;
    logic [8:0] x;

    // Power-on reset
    tick(2);
    check9("por_I_term0", I_term0, 9'd0);
    check9("por_I_term1", I_term1, 9'd0);
    check("por_done", {30'd0, done}, 32'd0);
    check("por_ovr", {30'd0, ovr}, 32'd0);
    rst_n = 1'b1;
    moving = 1'b1;

    // Basic update: integ0 = 100 -> I_term0 = 1
    strobe(2'b01, 12'sd100, 12'sd0, k);
    push(k + 3, 0, 9'd1, 9'd0);
    tick(4);

    // Saturation: +2000 -> 511 (I_term1 7), then -2048 -> -512, integ1 = -1
    strobe(2'b10, 12'sd0, 12'sd2000, k);
    push(k + 3, 1, 9'd1, 9'd7);
    tick(4);
    strobe(2'b10, 12'sd0, -12'sd2048, k);
    push(k + 3, 1, 9'd1, 9'h1FF);
    tick(4);

    // Simultaneous strobes from reset: ch0 first, ch1 three cycles later
    do_reset();
    strobe(2'b11, 12'sd64, 12'sd128, k);
    push(k + 3, 0, 9'd1, 9'd0);
    push(k + 6, 1, 9'd1, 9'd2);
    tick(7);
    // Last served was ch1, so ch0 goes first again
    strobe(2'b11, 12'sd64, -12'sd64, k);
    push(k + 3, 0, 9'd2, 9'd2);
    push(k + 6, 1, 9'd2, 9'd1);
    tick(7);

    // Overflow freeze: 32 x 511 = 16352, the 33rd update holds
    do_reset();
    for (int n = 1; n <= 33; n++) begin
      strobe(2'b01, 12'sd2047, 12'sd0, k);
      x = (n <= 32) ? 9'((511 * n) / 64) : 9'd255;
      push(k + 3, 0, x, 9'd0);
      tick(3);
    end
    check9("freeze_I_term0", I_term0, 9'd255);

    // moving dropped during LOAD: update aborted, integrators cleared
    @(negedge clk);
    err_vld = 2'b01;
    err0 = 12'sd100;
    @(negedge clk);
    err_vld = 2'b00;
    @(negedge clk);
    moving = 1'b0;
    @(negedge clk);
    check9("drop_I_term0", I_term0, 9'd0);
    check9("drop_I_term1", I_term1, 9'd0);
    check("drop_done", {30'd0, done}, 32'd0);
    err_vld = 2'b11;
    err0 = 12'sd500;
    err1 = 12'sd500;
    @(negedge clk);
    err_vld = 2'b00;
    check("drop_done2", {30'd0, done}, 32'd0);
    moving = 1'b1;
    tick(4);
    strobe(2'b10, 12'sd0, 12'sd200, k);
    push(k + 3, 1, 9'd0, 9'd3);
    tick(4);

    // Overrun: ch1 re-strobed while pending behind the ch0 update
    check("pre_ovr", {30'd0, ovr}, 32'd0);
    @(negedge clk);
    k = cyc;
    err_vld = 2'b11;
    err0 = 12'sd64;
    err1 = 12'sd64;
    @(negedge clk);
    err_vld = 2'b10;
    err1 = 12'sd320;
    @(negedge clk);
    err_vld = 2'b00;
    push(k + 3, 0, 9'd1, 9'd3);
    push(k + 6, 1, 9'd1, 9'd8);
    tick(1);
    check("ovr_set", {30'd0, ovr}, 32'd2);
    tick(6);
    check("ovr_sticky", {30'd0, ovr}, 32'd2);
    moving = 1'b0;
    tick(2);
    check("ovr_moving_low", {30'd0, ovr}, 32'd2);
    check9("ovr_drop_I_term1", I_term1, 9'd0);
    moving = 1'b1;
    tick(2);
    do_reset();

    // All expected updates must have been observed
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL missing_done: %0d expected updates never seen, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
